ula_controlador: RTL and testbench
==================================

ULA_CONTROLADOR -- requirements
Module: ula_controlador

Interface
REQ-001 Parameter N, default 8, data width of operands and result.
REQ-002 Parameter DEPTH, default 4, number of entries in the instruction FIFO (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers an instruction.
REQ-006 in_ready  output  1  FIFO can accept an instruction.
REQ-007 in_op  input  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 eq, 111 neq).
REQ-008 in_a, in_b  input  N  operands.
REQ-009 alu_a, alu_b  output  N  registered operands driven to the ALU.
REQ-010 alu_op  output  3  registered opcode driven to the ALU.
REQ-011 alu_s  input  N  ALU registered result.
REQ-012 alu_flag  input  1  ALU carry/borrow flag (combinational from ALU input registers and opcode).
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_s  output  N  captured result; out_flag output 1 captured flag; out_op output 3 opcode of the result.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 count  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 The block SHALL accept an instruction into the FIFO on any edge where in_valid && in_ready.
REQ-019 in_ready SHALL equal (count < DEPTH), independent of same-cycle pop.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 Pushes when full SHALL be ignored; no pop when empty.
REQ-022 FSM states SHALL be IDLE, EX1, EX2, EX3, DONE.
REQ-023 IDLE: if count>0, pop head, load alu_a/alu_b/alu_op from it, go EX1; else stay.
REQ-024 EX1 -> EX2 unconditionally (ALU input registers capture at this edge).
REQ-025 EX2 -> EX3 unconditionally, latching alu_flag into an internal flag register at this edge.
REQ-026 EX3 -> DONE, latching alu_s into out_s, the flag register into out_flag, alu_op into out_op.
REQ-027 out_valid SHALL be 1 exactly while in DONE.
REQ-028 DONE: if out_ready, go IDLE and drop out_valid; else stay with out_s/out_flag/out_op stable.
REQ-029 alu_a, alu_b, alu_op SHALL hold their values from IDLE exit until the next pop.
REQ-030 Issue-to-out_valid latency SHALL be 4 edges after pop; minimum issue interval 5 cycles.
REQ-031 At most one instruction SHALL be in execution; no new issue until the result is consumed.
REQ-032 Results SHALL leave in FIFO (arrival) order.
REQ-033 For opcodes 010-111, out_flag SHALL equal the ALU flag as sampled (expected 0).
REQ-034 FIFO pushes SHALL continue during EX1-DONE.

Reset
REQ-035 On rst=1 at an edge: state IDLE, count 0, pointers 0, flag register 0.
REQ-036 Reset values: out_valid 0, out_s 0, out_flag 0, out_op 0, alu_a 0, alu_b 0, alu_op 0, busy 0, in_ready 1.
REQ-037 Reset mid-operation SHALL abort the instruction in execution and discard FIFO contents; no partial result is emitted.
REQ-038 rst SHALL take priority over push, pop and out_ready.

Verification
REQ-039 Push {000, a=200, b=100}, out_ready=1 -> out_valid 4 edges after pop, out_s=0x2C, out_flag=1, out_op=000.
REQ-040 Push {001, a=5, b=10} -> out_s=0xFB, out_flag=1; push {001, a=10, b=5} -> out_s=0x05, out_flag=0.
REQ-041 Push {110, a=b=0x3C} -> out_s=0x01, out_flag=0; then {111, a=0x3C, b=0x3D} -> out_s=0x01, out_flag=0.
REQ-042 out_ready=0, push back-to-back until in_ready=0 -> exactly DEPTH+1 accepted, count=DEPTH; release out_ready -> all results in order, count returns to 0.
REQ-043 Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_s, out_flag stable; alu_* unchanged; no pop.
REQ-044 Assert rst during EX2 with 2 entries queued -> next cycle out_valid=0, busy=0, count=0, in_ready=1; no result appears afterwards.

Source files
------------

// File: rtl/ula_controlador.sv
// ula_controlador: instruction FIFO feeding an external ALU through a
// fixed five-state sequence (IDLE, EX1, EX2, EX3, DONE). Only one
// instruction is in flight at a time, and results leave in arrival order.
module ula_controlador #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    output logic [2:0]               alu_op,
    input  logic [N-1:0]             alu_s,
    input  logic                     alu_flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_s,
    output logic                     out_flag,
    output logic [2:0]               out_op,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 + 2 * N;

    typedef enum logic [2:0] {IDLE, EX1, EX2, EX3, DONE} state_t;

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [EW-1:0]   head;
    logic            flag_q;
    logic            push;
    logic            pop;

    // in_ready depends only on occupancy, so a pop in the same cycle does
    // not open a slot early.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign head     = mem[rd_ptr];

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_op, in_a, in_b};
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue/execute/retire sequencer with all controller outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            flag_q    <= 1'b0;
            out_s     <= '0;
            out_flag  <= 1'b0;
            out_op    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {alu_op, alu_a, alu_b} <= head;
                        busy  <= 1'b1;
                        state <= EX1;
                    end
                end
                // ALU input registers capture alu_a/alu_b/alu_op on this edge.
                EX1: state <= EX2;
                // alu_flag is now valid from the ALU input registers.
                EX2: begin
                    flag_q <= alu_flag;
                    state  <= EX3;
                end
                EX3: begin
                    out_s     <= alu_s;
                    out_flag  <= flag_q;
                    out_op    <= alu_op;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_controlador.sv
// Directed-vector bench for ula_controlador with a small registered ALU model.
module tb_ula_controlador;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [2:0]             in_op = '0;
    logic [N-1:0]           in_a = '0;
    logic [N-1:0]           in_b = '0;
    logic [N-1:0]           alu_a, alu_b;
    logic [2:0]             alu_op;
    logic [N-1:0]           alu_s;
    logic                   alu_flag;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [N-1:0]           out_s;
    logic                   out_flag;
    logic [2:0]             out_op;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_err = 0;

    ula_controlador #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_s(alu_s), .alu_flag(alu_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_flag(out_flag), .out_op(out_op),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // ALU model: input registers, combinational flag, registered result.
    logic [N-1:0] ra, rb;
    logic [2:0]   rop;
    logic [N:0]   res;

    function automatic logic [N:0] alu_f(logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op);
        logic [N:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {(a < b), a - b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {1'b0, ~a};
            3'b110:  r = {1'b0, N'(a == b)};
            default: r = {1'b0, N'(a != b)};
        endcase
        return r;
    endfunction

    assign res      = alu_f(ra, rb, rop);
    assign alu_flag = res[N];

    always_ff @(posedge clk) begin
        ra    <= alu_a;
        rb    <= alu_b;
        rop   <= alu_op;
        alu_s <= res[N-1:0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One instruction through an idle, empty controller with out_ready=1.
    task automatic run_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] es, input logic ef);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(negedge clk);                      // push edge done
        in_valid = 1'b0;
        chk("push_count", count, 1);
        @(negedge clk);                      // pop edge done
        chk("pop_busy", busy, 1);
        chk("pop_count", count, 0);
        chk("pop_alu_a", alu_a, a);
        chk("pop_alu_op", alu_op, op);
        @(negedge clk);
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(negedge clk);                      // 4th edge counting the pop edge
        chk("lat_valid", out_valid, 1);
        chk("res_s", out_s, es);
        chk("res_flag", out_flag, ef);
        chk("res_op", out_op, op);
        @(negedge clk);
        chk("drop_valid", out_valid, 0);
        chk("drop_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        int t;
        int seen;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_s", out_s, 0);
        chk("rst_out_flag", out_flag, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Directed ALU vectors
        run_one(3'b000, 8'd200, 8'd100, 8'h2C, 1'b1);
        run_one(3'b001, 8'd5,   8'd10,  8'hFB, 1'b1);
        run_one(3'b001, 8'd10,  8'd5,   8'h05, 1'b0);
        run_one(3'b110, 8'h3C,  8'h3C,  8'h01, 1'b0);
        run_one(3'b111, 8'h3C,  8'h3D,  8'h01, 1'b0);
        run_one(3'b010, 8'hF0,  8'h3C,  8'h30, 1'b0);
        run_one(3'b011, 8'hF0,  8'h3C,  8'hFC, 1'b0);
        run_one(3'b100, 8'hF0,  8'h3C,  8'hCC, 1'b0);
        run_one(3'b101, 8'h0F,  8'h00,  8'hF0, 1'b0);
        run_one(3'b110, 8'h3C,  8'h3D,  8'h00, 1'b0);

        // Fill with out_ready low: item i = {add, 10i+1, i}
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!in_ready) break;
            in_valid = 1'b1; in_op = 3'b000; in_a = 8'(10 * i + 1); in_b = 8'(i);
            accepted++;
        end
        chk("fill_accepted", accepted, DEPTH + 1);
        chk("fill_count", count, DEPTH);
        chk("fill_in_ready", in_ready, 0);
        in_a = 8'hAA;                         // push attempt while full
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_ignored", count, DEPTH);

        // Hold in DONE with out_ready low
        t = 0;
        while (!out_valid && t < 30) begin @(negedge clk); t++; end
        chk("hold_reach", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_s", out_s, 8'd1);
            chk("hold_flag", out_flag, 0);
            chk("hold_alu_a", alu_a, 8'd1);
            chk("hold_alu_b", alu_b, 8'd0);
            chk("hold_count", count, DEPTH);
            @(negedge clk);
        end

        // Drain in order
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            t = 0;
            while (!out_valid && t < 30) begin @(negedge clk); t++; end
            chk("drain_valid", out_valid, 1);
            chk("drain_s", out_s, 32'(11 * k + 1));
            @(negedge clk);
        end
        chk("drain_count", count, 0);
        chk("drain_busy", busy, 0);

        // Reset during EX2 with two entries queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 3'b000; in_a = 8'(i + 7); in_b = 8'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("ex2_busy", busy, 1);
        chk("ex2_count", count, 2);
        chk("ex2_alu_a", alu_a, 8'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_s", out_s, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("no_result_after_rst", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
